pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_mc_cnt.sv | 28 ++
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the enable/clear control bundle and default multicycle latency.
package pipe_ctrl_pkg;

   localparam int MC_LAT_DEF = 32;
   localparam int CNT_W_DEF  = 6;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      MC_WAIT = 2'b01,
      HALT    = 2'b10
   } state_t;

   typedef struct packed {
      logic pc_en;
      logic en_ifid;
      logic en_idex;
      logic en_exmem;
      logic en_memwb;
      logic clr_ifid;
      logic clr_idex;
      logic clr_exmem;
   } ctrl_t;

   // Free-running pipeline: every stage loads, nothing cleared.
   localparam ctrl_t CTRL_RUN  = 8'b11111_000;
   localparam ctrl_t CTRL_HOLD = 8'b00000_000;

endpackage

// File: rtl/pipe_ctrl_mc_cnt.sv
// Loadable down-counter tracking remaining multicycle EX cycles; zero flag is
// combinational from the count. Stops at zero, no backpressure.
module mc_cnt #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: combinational enables/clears from FSM state
// and hazards; stalls the front end during multicycle EX ops and on halt. Optional PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_LAT = MC_LAT_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_use_hz,
   input  logic        br_taken,
   input  logic        mc_start,
   input  logic        halt_req,
   input  logic        resume,
   output logic        pc_en,
   output logic        en_ifid,
   output logic        en_idex,
   output logic        en_exmem,
   output logic        en_memwb,
   output logic        clr_ifid,
   output logic        clr_idex,
   output logic        clr_exmem,
   output logic [1:0]  state,
   output logic        mc_busy
`ifdef PIPE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   state_t cur_st;
   state_t nxt_st;
   ctrl_t  ctrl;
   ctrl_t  ctrl_out;
   logic   cnt_load;
   logic   cnt_dec;
   logic   cnt_zero;
   logic   pend_set;
   logic   halt_pend;

   mc_cnt #(.CNT_W(CNT_W)) u_mc_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (CNT_W'(MC_LAT - 1)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      ctrl     = CTRL_RUN;
      nxt_st   = cur_st;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      pend_set = 1'b0;
      case (cur_st)
         RUN: begin
            if (br_taken) begin
               ctrl.clr_ifid = 1'b1;
               ctrl.clr_idex = 1'b1;
               if (halt_req) nxt_st = HALT;
            end else if (mc_start) begin
               // A halt arriving with the issue is honoured once the op drains.
               nxt_st   = MC_WAIT;
               cnt_load = 1'b1;
               pend_set = halt_req;
            end else begin
               if (load_use_hz) begin
                  ctrl.pc_en    = 1'b0;
                  ctrl.en_ifid  = 1'b0;
                  ctrl.clr_idex = 1'b1;
               end
               if (halt_req) nxt_st = HALT;
            end
         end
         MC_WAIT: begin
            ctrl.pc_en   = 1'b0;
            ctrl.en_ifid = 1'b0;
            ctrl.en_idex = 1'b0;
            if (!cnt_zero) begin
               ctrl.clr_exmem = 1'b1;
               cnt_dec        = 1'b1;
               pend_set       = halt_req;
            end else begin
               nxt_st = (halt_pend || halt_req) ? HALT : RUN;
            end
         end
         HALT: begin
            ctrl = CTRL_HOLD;
            if (resume) nxt_st = RUN;
         end
         default: nxt_st = RUN;
      endcase
   end

   // Reset forces the free-running control word regardless of hazard inputs.
   assign ctrl_out = rst ? ctrl : CTRL_RUN;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_st    <= RUN;
         halt_pend <= 1'b0;
      end else begin
         cur_st    <= nxt_st;
         halt_pend <= (nxt_st == HALT) ? 1'b0 : (halt_pend | pend_set);
      end
   end

   assign pc_en     = ctrl_out.pc_en;
   assign en_ifid   = ctrl_out.en_ifid;
   assign en_idex   = ctrl_out.en_idex;
   assign en_exmem  = ctrl_out.en_exmem;
   assign en_memwb  = ctrl_out.en_memwb;
   assign clr_ifid  = ctrl_out.clr_ifid;
   assign clr_idex  = ctrl_out.clr_idex;
   assign clr_exmem = ctrl_out.clr_exmem;
   assign state     = cur_st;
   assign mc_busy   = (cur_st == MC_WAIT);

`ifdef PIPE_CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (!ctrl_out.pc_en && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, multicycle wait, halt/resume, async reset.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic load_use_hz = 1'b0, br_taken = 1'b0, mc_start = 1'b0, halt_req = 1'b0, resume = 1'b0;
   logic pc_en, en_ifid, en_idex, en_exmem, en_memwb, clr_ifid, clr_idex, clr_exmem, mc_busy;
   logic [1:0] state;
   logic pc_en1, en_ifid1, en_idex1, en_exmem1, en_memwb1, clr_ifid1, clr_idex1, clr_exmem1, mc_busy1;
   logic [1:0] state1;
`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cycles, stall_cycles1;
`endif

   int pass  = 0;
   int total = 0;

   localparam logic [7:0] RUNV = 8'b11111_000;
   localparam logic [7:0] BRV  = 8'b11111_110;
   localparam logic [7:0] LUV  = 8'b00111_010;
   localparam logic [7:0] MCW  = 8'b00011_001;
   localparam logic [7:0] MCZ  = 8'b00011_000;
   localparam logic [7:0] HLT  = 8'b00000_000;

   wire [7:0] ctl  = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, clr_ifid, clr_idex, clr_exmem};
   wire [7:0] ctl1 = {pc_en1, en_ifid1, en_idex1, en_exmem1, en_memwb1, clr_ifid1, clr_idex1, clr_exmem1};

   always #5 clk = ~clk;

   pipe_ctrl #(.MC_LAT(4), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .load_use_hz(load_use_hz), .br_taken(br_taken),
      .mc_start(mc_start), .halt_req(halt_req), .resume(resume),
      .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
      .en_memwb(en_memwb), .clr_ifid(clr_ifid), .clr_idex(clr_idex),
      .clr_exmem(clr_exmem), .state(state), .mc_busy(mc_busy)
`ifdef PIPE_CTRL_PERF_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   pipe_ctrl #(.MC_LAT(1), .CNT_W(6)) dut1 (
      .clk(clk), .rst(rst), .load_use_hz(load_use_hz), .br_taken(br_taken),
      .mc_start(mc_start), .halt_req(halt_req), .resume(resume),
      .pc_en(pc_en1), .en_ifid(en_ifid1), .en_idex(en_idex1), .en_exmem(en_exmem1),
      .en_memwb(en_memwb1), .clr_ifid(clr_ifid1), .clr_idex(clr_idex1),
      .clr_exmem(clr_exmem1), .state(state1), .mc_busy(mc_busy1)
`ifdef PIPE_CTRL_PERF_CNT_EN
      , .stall_cycles(stall_cycles1)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      br_taken = 1'b1; load_use_hz = 1'b1;
      #2;
      total++; if (ctl !== RUNV) $display("FAIL reset_ctl: got %b want %b", ctl, RUNV); else pass++;
      total++; if (state !== 2'b00) $display("FAIL reset_state: got %b want 00", state); else pass++;
      total++; if (mc_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", mc_busy); else pass++;
      br_taken = 1'b0; load_use_hz = 1'b0;
      #1 rst = 1'b1;
      tick();
      total++; if (ctl !== RUNV) $display("FAIL run_idle: got %b want %b", ctl, RUNV); else pass++;
   endtask

   task automatic test_load_use();
      load_use_hz = 1'b1; #1;
      total++; if (ctl !== LUV) $display("FAIL load_use_stall: got %b want %b", ctl, LUV); else pass++;
      tick(); load_use_hz = 1'b0; #1;
      total++; if (ctl !== RUNV) $display("FAIL load_use_after: got %b want %b", ctl, RUNV); else pass++;
      total++; if (state !== 2'b00) $display("FAIL load_use_state: got %b want 00", state); else pass++;
   endtask

   task automatic test_branch();
      load_use_hz = 1'b1; br_taken = 1'b1; #1;
      total++; if (ctl !== BRV) $display("FAIL br_over_lu: got %b want %b", ctl, BRV); else pass++;
      tick(); load_use_hz = 1'b0; br_taken = 1'b0; #1;
      total++; if (ctl !== RUNV) $display("FAIL br_after: got %b want %b", ctl, RUNV); else pass++;
   endtask

   task automatic test_multicycle();
      mc_start = 1'b1; load_use_hz = 1'b1; #1;
      total++; if (ctl !== RUNV) $display("FAIL mc_issue: got %b want %b", ctl, RUNV); else pass++;
      tick(); mc_start = 1'b0; load_use_hz = 1'b1; br_taken = 1'b1; #1;
      total++; if (state !== 2'b01) $display("FAIL mc_state: got %b want 01", state); else pass++;
      total++; if (ctl !== MCW) $display("FAIL mc_w0_ignores_hz: got %b want %b", ctl, MCW); else pass++;
      load_use_hz = 1'b0; br_taken = 1'b0;
      for (int i = 1; i < 4; i++) begin
         tick();
         total++; if (mc_busy !== 1'b1) $display("FAIL mc_busy_%0d: got %b want 1", i, mc_busy); else pass++;
         total++; if (ctl !== ((i < 3) ? MCW : MCZ)) $display("FAIL mc_ctl_%0d: got %b want %b", i, ctl, (i < 3) ? MCW : MCZ); else pass++;
      end
      tick();
      total++; if (state !== 2'b00 || ctl !== RUNV) $display("FAIL mc_done: got %b/%b want 00/%b", state, ctl, RUNV); else pass++;
   endtask

   task automatic test_halt_in_mc();
      mc_start = 1'b1;
      tick(); mc_start = 1'b0; halt_req = 1'b1;
      tick(); halt_req = 1'b0;
      tick(); tick();
      total++; if (state !== 2'b01 || ctl !== MCZ) $display("FAIL halt_mc_last: got %b/%b want 01/%b", state, ctl, MCZ); else pass++;
      tick();
      total++; if (state !== 2'b10) $display("FAIL halt_enter: got %b want 10", state); else pass++;
      total++; if (ctl !== HLT) $display("FAIL halt_ctl: got %b want %b", ctl, HLT); else pass++;
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      resume = 1'b1; #1;
      total++; if (state !== 2'b10) $display("FAIL halt_hold: got %b want 10", state); else pass++;
      tick(); resume = 1'b0; #1;
      total++; if (state !== 2'b00 || ctl !== RUNV) $display("FAIL resume: got %b/%b want 00/%b", state, ctl, RUNV); else pass++;
   endtask

   task automatic test_halt_run();
      halt_req = 1'b1; load_use_hz = 1'b1; #1;
      total++; if (ctl !== LUV) $display("FAIL halt_run_lu: got %b want %b", ctl, LUV); else pass++;
      tick(); halt_req = 1'b0; load_use_hz = 1'b0; #1;
      total++; if (state !== 2'b10) $display("FAIL halt_run_state: got %b want 10", state); else pass++;
      resume = 1'b1; tick(); resume = 1'b0; #1;
      total++; if (state !== 2'b00) $display("FAIL halt_run_resume: got %b want 00", state); else pass++;
   endtask

   task automatic test_reset_mid_mc();
      int n;
      mc_start = 1'b1;
      tick(); mc_start = 1'b0;
      tick();
      total++; if (mc_busy !== 1'b1) $display("FAIL rmid_busy: got %b want 1", mc_busy); else pass++;
      rst = 1'b0; #1;
      total++; if (state !== 2'b00 || mc_busy !== 1'b0) $display("FAIL rmid_async: got %b/%b want 00/0", state, mc_busy); else pass++;
      #1 rst = 1'b1;
      tick(); mc_start = 1'b1;
      tick(); mc_start = 1'b0;
      n = 0;
      while (mc_busy === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      total++; if (n != 4) $display("FAIL rmid_restart_len: got %0d want 4", n); else pass++;
   endtask

   task automatic test_mclat1();
      rst = 1'b0; #1 rst = 1'b1;
      tick(); mc_start = 1'b1;
      tick(); mc_start = 1'b0; #1;
      total++; if (state1 !== 2'b01 || ctl1 !== MCZ) $display("FAIL lat1_wait: got %b/%b want 01/%b", state1, ctl1, MCZ); else pass++;
      tick();
      total++; if (state1 !== 2'b00 || ctl1 !== RUNV) $display("FAIL lat1_done: got %b/%b want 00/%b", state1, ctl1, RUNV); else pass++;
   endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
   task automatic test_perf();
      rst = 1'b0; #1 rst = 1'b1;
      total++; if (stall_cycles !== 32'd0) $display("FAIL perf_reset: got %0d want 0", stall_cycles); else pass++;
      tick(); load_use_hz = 1'b1;
      tick(); tick(); tick(); load_use_hz = 1'b0; mc_start = 1'b1;
      tick(); mc_start = 1'b0;
      tick(); tick(); tick(); tick();
      total++; if (stall_cycles !== 32'd7) $display("FAIL perf_count: got %0d want 7", stall_cycles); else pass++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_multicycle();
      test_halt_in_mc();
      test_halt_run();
      test_reset_mid_mc();
      test_mclat1();
`ifdef PIPE_CTRL_PERF_CNT_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
